obi_lsu_mgr: RTL and testbench
==============================

OBI_LSU_MGR -- requirements
Module: obi_lsu_mgr

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of the core and OBI address ports.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 lsu_req_i  in  1  core access request; accepted when lsu_ready_o=1.
REQ-005 lsu_we_i  in  1  1=store, 0=load.
REQ-006 lsu_size_i  in  2  access size: 00=byte, 01=half, 10=word, 11=illegal.
REQ-007 lsu_unsigned_i  in  1  load result zero-extended when 1, sign-extended when 0.
REQ-008 lsu_addr_i  in  ADDR_WIDTH  byte address.
REQ-009 lsu_wdata_i  in  32  store data, right-aligned.
REQ-010 lsu_ready_o  out  1  block can accept a request this cycle.
REQ-011 lsu_rvalid_o  out  1  one-cycle completion pulse for loads and stores.
REQ-012 lsu_rdata_o  out  32  extended load data; valid with lsu_rvalid_o.
REQ-013 lsu_err_o  out  1  completion carries an error; valid with lsu_rvalid_o.
REQ-014 lsu_misaligned_o  out  1  error cause is misalignment or illegal size; valid with lsu_rvalid_o.
REQ-015 obi_req_o / obi_gnt_i  out / in  1 / 1  OBI address-phase handshake.
REQ-016 obi_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 00.
REQ-017 obi_we_o, obi_be_o, obi_wdata_o  out  1, 4, 32  write enable, byte enables, lane-placed write data.
REQ-018 obi_rvalid_i, obi_rdata_i, obi_err_i  in  1, 32, 1  OBI response phase.

Function
REQ-019 FSM states: IDLE, ADDR (obi_req_o=1, awaiting gnt), RESP (awaiting obi_rvalid_i), DONE (lsu_rvalid_o=1 for one cycle).
REQ-020 lsu_ready_o SHALL be 1 only in IDLE; an accepted request is registered, so core inputs may change on the next cycle.
REQ-021 Byte enables: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
REQ-022 Write data: byte replicated to all 4 lanes; half replicated to both halves; word passed unchanged.
REQ-023 Misalignment: half with addr[0]=1, word with addr[1:0]!=00, or size=11 SHALL issue no OBI request; go IDLE->DONE with lsu_err_o=1, lsu_misaligned_o=1, lsu_rdata_o=0.
REQ-024 Legal request: IDLE->ADDR on acceptance; obi_req_o first asserts in the cycle after acceptance.
REQ-025 In ADDR, obi_addr_o/we/be/wdata SHALL hold stable until gnt; obi_req_o SHALL never drop before gnt.
REQ-026 ADDR->RESP in the cycle gnt=1; obi_req_o=0 in RESP; exactly one transaction outstanding at any time.
REQ-027 obi_rvalid_i SHALL be ignored outside RESP; an rvalid in the same cycle as gnt is not a legal response.
REQ-028 RESP->DONE on obi_rvalid_i; obi_rdata_i is captured in that cycle, and lane select uses the registered addr[1:0] and size.
REQ-029 Load data: the selected byte or half is shifted to bit 0 and sign- or zero-extended per lsu_unsigned_i; a word load passes obi_rdata_i unchanged.
REQ-030 Store completion: lsu_rdata_o=0.
REQ-031 DONE->IDLE unconditionally; minimum legal transaction latency is acceptance + 3 cycles to lsu_rvalid_o with gnt and rvalid each granted at the earliest cycle.
REQ-032 Back-to-back: a new request is accepted in the cycle after DONE.

Reset
REQ-033 Reset SHALL asynchronously force IDLE, obi_req_o=0, lsu_ready_o=1, lsu_rvalid_o=0, lsu_err_o=0, lsu_misaligned_o=0, lsu_rdata_o=0, and obi_addr_o/be/wdata/we=0.
REQ-034 Reset mid-transaction SHALL drop obi_req_o immediately, produce no completion, and ignore any late rvalid after reset release while in IDLE.

Configuration
REQ-035 Macro OBI_LSU_BUS_ERR_EN defined: obi_err_i sampled with rvalid sets lsu_err_o=1, lsu_misaligned_o=0, lsu_rdata_o=0.
REQ-036 OBI_LSU_BUS_ERR_EN undefined: obi_err_i is ignored; lsu_err_o is set only by misalignment.

Verification
REQ-037 Store word 0xCAFEBABE to 0x10; gnt same cycle as req; rvalid next cycle -> be=1111, addr=0x10, wdata=0xCAFEBABE, one lsu_rvalid_o pulse, err=0.
REQ-038 Signed byte load at 0x13 with rdata=0x80FFFFFF -> be=1000, addr=0x10, lsu_rdata_o=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-039 Store half 0x1234 to 0x22 with gnt held low 5 cycles -> req, addr=0x20, be=1100, wdata=0x12341234 stable all 6 cycles.
REQ-040 Load word at 0x06 -> no obi_req_o, lsu_rvalid_o with err=1, misaligned=1, rdata=0.
REQ-041 With OBI_LSU_BUS_ERR_EN, load at 0x40 with obi_err_i=1 at rvalid -> err=1, misaligned=0, rdata=0; without the macro -> err=0, rdata=obi_rdata_i.
REQ-042 Assert reset in RESP, then deliver rvalid after release -> no lsu_rvalid_o, lsu_ready_o=1.

Source files
------------

// File: rtl/obi_lsu_mgr.sv
// obi_lsu_mgr: turns a core load/store request into a single OBI transaction.
// Handles lane placement and byte enables, rejects misaligned or illegal-size
// accesses locally, and extends load data.
// Build option: define OBI_LSU_BUS_ERR_EN to report obi_err_i as a load/store error.
module obi_lsu_mgr #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_ready_o,
    output logic                  lsu_rvalid_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  lsu_misaligned_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [31:0]           obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [31:0]           obi_rdata_i,
    input  logic                  obi_err_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [BW-1:0]         be_q, be_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  mis_q, mis_d;

    logic                  misaligned_c;
    logic [7:0]            byte_c;
    logic [15:0]           half_c;
    logic [DW-1:0]         load_c;

`ifndef OBI_LSU_BUS_ERR_EN
    logic                  unused_bus_err;
    assign unused_bus_err = obi_err_i;
`endif

    // Reject illegal size or an address not aligned to the access size
    always_comb begin
        misaligned_c = 1'b0;
        case (lsu_size_i)
            2'b01:   misaligned_c = lsu_addr_i[0];
            2'b10:   misaligned_c = (lsu_addr_i[1:0] != 2'b00);
            2'b11:   misaligned_c = 1'b1;
            default: misaligned_c = 1'b0;
        endcase
    end

    // Pick the addressed lane from the response and extend it to 32 bits
    always_comb begin
        byte_c = 8'(obi_rdata_i >> {off_q, 3'b000});
        half_c = off_q[1] ? obi_rdata_i[31:16] : obi_rdata_i[15:0];
        case (size_q)
            2'b00:   load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{~uns_q & half_c[15]}}, half_c};
            default: load_c = obi_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        mis_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    size_d = lsu_size_i;
                    uns_d  = lsu_unsigned_i;
                    off_d  = lsu_addr_i[1:0];
                    if (misaligned_c) begin
                        state_d  = DONE;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        mis_d    = 1'b1;
                    end else begin
                        state_d = ADDR;
                        req_d   = 1'b1;
                        addr_d  = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        we_d    = lsu_we_i;
                        case (lsu_size_i)
                            2'b00: begin
                                be_d    = BW'(4'b0001 << lsu_addr_i[1:0]);
                                wdata_d = {4{lsu_wdata_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{lsu_wdata_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = lsu_wdata_i;
                            end
                        endcase
                    end
                end
            end
            ADDR: begin
                if (obi_gnt_i) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                end
            end
            RESP: begin
                if (obi_rvalid_i) begin
                    state_d  = DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? '0 : load_c;
`ifdef OBI_LSU_BUS_ERR_EN
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
        end
    end

    assign lsu_ready_o      = ready_q;
    assign lsu_rvalid_o     = rvalid_q;
    assign lsu_rdata_o      = rdata_q;
    assign lsu_err_o        = err_q;
    assign lsu_misaligned_o = mis_q;
    assign obi_req_o        = req_q;
    assign obi_addr_o       = addr_q;
    assign obi_we_o         = we_q;
    assign obi_be_o         = be_q;
    assign obi_wdata_o      = wdata_q;

endmodule

// File: tb/tb_obi_lsu_mgr.sv
// Directed bench for obi_lsu_mgr with a completion scoreboard.
module tb_obi_lsu_mgr;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_ready_o, lsu_rvalid_o, lsu_err_o, lsu_misaligned_o;
    logic [31:0] lsu_rdata_o;
    logic        obi_req_o, obi_gnt_i, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i, obi_err_i;
    logic [31:0] obi_rdata_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    obi_lsu_mgr #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_misaligned_o(lsu_misaligned_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (lsu_rvalid_o === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rvalid observed=1 expected=0");
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk32("sb_rdata", lsu_rdata_o, e.rdata);
                chk1("sb_err", lsu_err_o, e.err);
                chk1("sb_misaligned", lsu_misaligned_o, e.mis);
            end
        end
    end

    // One full transaction; returns at the negedge of the DONE cycle
    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gnt_dly, input int rv_dly,
                       input logic [31:0] rdata, input logic berr, input logic spurious,
                       input logic [3:0] e_be, input logic [31:0] e_wdata,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_mis);
        exp_t e;
        @(negedge clk);
        chk1("ready_idle", lsu_ready_o, 1'b1);
        chk1("rvalid_one_cycle", lsu_rvalid_o, 1'b0);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_unsigned_i = uns; lsu_addr_i = addr; lsu_wdata_i = wdata;
        e.rdata = e_rdata; e.err = e_err; e.mis = e_mis;
        exp_q.push_back(e);
        @(negedge clk);
        lsu_req_i = 1'b0; lsu_addr_i = 32'hFFFF_FFFF; lsu_wdata_i = 32'h5A5A_A5A5;
        lsu_size_i = 2'b10; lsu_we_i = ~we; lsu_unsigned_i = ~uns;
        chk1("ready_busy", lsu_ready_o, 1'b0);
        if (e_mis) begin
            chk1("mis_no_req", obi_req_o, 1'b0);
            chk1("mis_rvalid", lsu_rvalid_o, 1'b1);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                obi_gnt_i    = (i == gnt_dly);
                obi_rvalid_i = spurious && (i == gnt_dly);
                chk1("addr_req", obi_req_o, 1'b1);
                chk32("addr_addr", obi_addr_o, addr & 32'hFFFF_FFFC);
                chk32("addr_be", 32'(obi_be_o), 32'(e_be));
                chk32("addr_wdata", obi_wdata_o, e_wdata);
                chk1("addr_we", obi_we_o, we);
                chk1("addr_no_rvalid", lsu_rvalid_o, 1'b0);
                @(negedge clk);
            end
            obi_gnt_i = 1'b0;
            for (int i = 0; i <= rv_dly; i++) begin
                obi_rvalid_i = (i == rv_dly);
                obi_rdata_i  = (i == rv_dly) ? rdata : 32'h0BAD_0BAD;
                obi_err_i    = (i == rv_dly) && berr;
                chk1("resp_req_low", obi_req_o, 1'b0);
                chk1("resp_no_rvalid", lsu_rvalid_o, 1'b0);
                chk1("resp_ready", lsu_ready_o, 1'b0);
                @(negedge clk);
            end
            obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
            chk1("done_rvalid", lsu_rvalid_o, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] e41_rdata;
        logic        e41_err;
        reset = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
        lsu_addr_i = '0; lsu_wdata_i = '0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = '0;
        repeat (2) @(negedge clk);
        chk1("rst_ready", lsu_ready_o, 1'b1);
        chk1("rst_req", obi_req_o, 1'b0);
        chk1("rst_rvalid", lsu_rvalid_o, 1'b0);
        chk1("rst_err", lsu_err_o, 1'b0);
        chk1("rst_mis", lsu_misaligned_o, 1'b0);
        chk32("rst_rdata", lsu_rdata_o, 32'h0);
        chk32("rst_addr", obi_addr_o, 32'h0);
        chk32("rst_be", 32'(obi_be_o), 32'h0);
        chk32("rst_wdata", obi_wdata_o, 32'h0);
        chk1("rst_we", obi_we_o, 1'b0);
        reset = 1'b0;

        // Word store, earliest gnt/rvalid
        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_BABE, 0, 0, 32'h0, 1'b0, 1'b0,
            4'b1111, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b0);
        // Byte loads at lane 3, signed then unsigned
        run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0,
            4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
        run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 0, 32'h80FF_FFFF, 1'b0, 1'b0,
            4'b1000, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
        // Half store with gnt held off five cycles
        run(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234, 5, 0, 32'h0, 1'b0, 1'b0,
            4'b1100, 32'h1234_1234, 32'h0, 1'b0, 1'b0);
        // Misaligned word, misaligned half, illegal size
        run(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run(1'b1, 2'b01, 1'b0, 32'h01, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        run(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        // Bus error on a word load
`ifdef OBI_LSU_BUS_ERR_EN
        e41_rdata = 32'h0; e41_err = 1'b1;
`else
        e41_rdata = 32'hDEAD_BEEF; e41_err = 1'b0;
`endif
        run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0,
            4'b1111, 32'h0, e41_rdata, e41_err, 1'b0);
        // Half loads, upper signed and lower unsigned/signed
        run(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1, 1, 32'h8001_7FFF, 1'b0, 1'b0,
            4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0);
        run(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0, 1'b0,
            4'b0011, 32'h0, 32'h0000_7FFF, 1'b0, 1'b0);
        run(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 0, 2, 32'h1234_8000, 1'b0, 1'b0,
            4'b0011, 32'h0, 32'hFFFF_8000, 1'b0, 1'b0);
        // Byte loads in inner lanes, byte store replication
        run(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 0, 32'h0000_8000, 1'b0, 1'b0,
            4'b0010, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
        run(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 0, 32'h007F_0000, 1'b0, 1'b0,
            4'b0100, 32'h0, 32'h0000_007F, 1'b0, 1'b0);
        run(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AB, 0, 1, 32'h0, 1'b0, 1'b0,
            4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0);
        // rvalid coinciding with gnt must not complete the access
        run(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1, 3, 32'h1357_9BDF, 1'b0, 1'b1,
            4'b1111, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0);

        // Reset while waiting for the response; late rvalid must be dropped
        @(negedge clk);
        chk1("pre_rst_ready", lsu_ready_o, 1'b1);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h50;
        @(negedge clk);
        lsu_req_i = 1'b0;
        obi_gnt_i = 1'b1;
        chk1("pre_rst_req", obi_req_o, 1'b1);
        @(negedge clk);
        obi_gnt_i = 1'b0;
        chk1("pre_rst_resp", obi_req_o, 1'b0);
        chk1("pre_rst_busy", lsu_ready_o, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk1("async_rst_ready", lsu_ready_o, 1'b1);
        chk1("async_rst_req", obi_req_o, 1'b0);
        chk1("async_rst_rvalid", lsu_rvalid_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hFEED_FACE;
        @(negedge clk);
        obi_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("late_rvalid_ignored", lsu_rvalid_o, 1'b0);
            chk1("late_rvalid_ready", lsu_ready_o, 1'b1);
            @(negedge clk);
        end
        chk32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
